// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART TX scheduler.
package uart_ctrl_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DONE = 2'd1,
      GAP       = 2'd2
   } state_t;

   // Bits needed to count 0..value-1; never narrower than one bit.
   function automatic int cnt_width(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < value) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping at N_REQ.
module uart_rr_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_winner,
   output logic             o_valid
);

   logic [IDX_W-1:0] w_cand;

   // Walk the requests starting at the pointer; the first hit wins.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      o_winner = '0;
      o_valid  = 1'b0;
      w_cand   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_cand = IDX_W'((int'(i_ptr) + i) % N_REQ);
         if (!o_valid && i_req[w_cand]) begin
            o_valid  = 1'b1;
            o_winner = w_cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte
// requesters. One byte per grant; done edge or timeout ends the grant.
// Optional loopback byte check enabled by macro UART_LOOPBACK_CHECK_EN.
module uart_tx_scheduler
   import uart_ctrl_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [BYTE_W*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]        ack,
   output logic [N_REQ-1:0]        err,
   output logic [N_REQ-1:0]        grant,
   output logic                    busy,
   output logic                    tx_start,
   output logic [BYTE_W-1:0]       tx_data,
`ifdef UART_LOOPBACK_CHECK_EN
   input  logic [BYTE_W-1:0]       rx_data,
   input  logic                    rx_done,
   output logic                    mismatch,
   output logic [7:0]              err_cnt,
`endif
   input  logic                    tx_done
);

   localparam int IDX_W = cnt_width(N_REQ);
   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
   localparam int GAP_W = cnt_width(GAP_CYCLES);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_owner;
   logic [BYTE_W-1:0]  r_tx_data;
   logic [CNT_W-1:0]   r_cnt;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic               r_tx_done_q;
   logic [N_REQ-1:0]   r_ack;
   logic [N_REQ-1:0]   r_err;
   logic [IDX_W-1:0]   w_winner;
   logic               w_valid;
   logic               w_done_rise;
   logic               w_timeout;
   logic [IDX_W-1:0]   w_ptr_next;

   uart_rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   // A done level already high when the grant starts never produces a rise.
   assign w_done_rise = tx_done & ~r_tx_done_q;
   assign w_timeout   = (r_cnt == TO_LAST);
   assign w_ptr_next  = (r_owner == IDX_LAST) ? '0 : r_owner + 1'b1;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_valid) w_next_state = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (w_done_rise || w_timeout) begin
               w_next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (r_gap_cnt == GAP_LAST) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Output decode; grant and start are only live while a byte is in flight.
   always_comb begin
      grant    = '0;
      tx_start = (r_state == WAIT_DONE);
      busy     = (r_state != IDLE);
      ack      = r_ack;
      err      = r_err;
      tx_data  = r_tx_data;
      if (r_state == WAIT_DONE) grant[r_owner] = 1'b1;
   end

   // Done edge detector history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_done_q <= 1'b0;
      end else begin
         r_tx_done_q <= tx_done;
      end
   end

   // Winner latch, timeout/gap counters, pointer and ack/err pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr     <= '0;
         r_owner   <= '0;
         r_tx_data <= '0;
         r_cnt     <= '0;
         r_gap_cnt <= '0;
         r_ack     <= '0;
         r_err     <= '0;
      end else begin
         r_ack <= '0;
         r_err <= '0;
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_owner   <= w_winner;
                  r_tx_data <= req_data[int'(w_winner)*BYTE_W +: BYTE_W];
                  r_cnt     <= '0;
               end
            end
            WAIT_DONE: begin
               // Done is tested first so it wins over a coincident timeout.
               if (w_done_rise) begin
                  r_ack[r_owner] <= 1'b1;
                  r_ptr          <= w_ptr_next;
                  r_gap_cnt      <= '0;
               end else if (w_timeout) begin
                  r_err[r_owner] <= 1'b1;
                  r_ptr          <= w_ptr_next;
                  r_gap_cnt      <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            GAP: begin
               r_gap_cnt <= r_gap_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef UART_LOOPBACK_CHECK_EN
   logic       r_rx_done_q;
   logic       r_mismatch;
   logic [7:0] r_err_cnt;
   logic       w_rx_rise;

   assign w_rx_rise = rx_done & ~r_rx_done_q;
   assign mismatch  = r_mismatch;
   assign err_cnt   = r_err_cnt;

   // Compare echoed bytes against the byte in flight; count saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_done_q <= 1'b0;
         r_mismatch  <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_rx_done_q <= rx_done;
         r_mismatch  <= 1'b0;
         if (w_rx_rise && (r_state == WAIT_DONE || r_state == GAP) &&
             (rx_data != r_tx_data)) begin
            r_mismatch <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (N_REQ=4, GAP_CYCLES=2,
// TIMEOUT_CYCLES=16). Loopback checks compile in with UART_LOOPBACK_CHECK_EN.
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  ack, err, grant;
   logic        busy, tx_start;
   logic [7:0]  tx_data;
   logic        tx_done = 1'b0;
`ifdef UART_LOOPBACK_CHECK_EN
   logic [7:0]  rx_data = '0;
   logic        rx_done = 1'b0;
   logic        mismatch;
   logic [7:0]  err_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_scheduler #(
      .N_REQ          (4),
      .GAP_CYCLES     (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .err      (err),
      .grant    (grant),
      .busy     (busy),
      .tx_start (tx_start),
      .tx_data  (tx_data),
`ifdef UART_LOOPBACK_CHECK_EN
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .mismatch (mismatch),
      .err_cnt  (err_cnt),
`endif
      .tx_done  (tx_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n   = 1'b0;
      req     = '0;
      tx_done = 1'b0;
`ifdef UART_LOOPBACK_CHECK_EN
      rx_done = 1'b0;
      rx_data = '0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   // Steps until tx_start is seen or the budget runs out.
   task automatic wait_start(output int cycles);
      cycles = 0;
      while (!tx_start && cycles < 20) begin
         step();
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_tests++;
      if ({ack, err, grant, busy, tx_start, tx_data} !== 22'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ack=%b err=%b grant=%b busy=%b start=%b data=%h want all 0",
                  ack, err, grant, busy, tx_start, tx_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      n_tests++;
      if (busy !== 1'b0 || grant !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b grant=%b want 0/0000", busy, grant);
      end
   endtask

   task automatic test_single();
      int bad;
      apply_reset();
      req      = 4'b0001;
      req_data = 32'h0000_005A;
      step();
      n_tests++;
      if (tx_start !== 1'b1 || tx_data !== 8'h5A || grant !== 4'b0001 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_start: got start=%b data=%h grant=%b busy=%b want 1/5a/0001/1",
                  tx_start, tx_data, grant, busy);
      end
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (ack !== 4'b0 || tx_start !== 1'b1) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL single_hold: got %0d bad cycles want 0", bad);
      end
      tx_done = 1'b1;
      step();
      n_tests++;
      if (ack !== 4'b0001 || tx_start !== 1'b0 || grant !== 4'b0) begin
         n_fail++;
         $display("FAIL single_ack: got ack=%b start=%b grant=%b want 0001/0/0000", ack, tx_start, grant);
      end
      req     = '0;
      tx_done = 1'b0;
      step();
      n_tests++;
      if (ack !== 4'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_gap: got ack=%b busy=%b want 0000/1", ack, busy);
      end
      step();
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_round_robin();
      int cyc;
      int exp_idx;
      logic [3:0] exp_oh;
      logic [7:0] exp_byte;
      apply_reset();
      req      = 4'b1111;
      req_data = 32'h4433_2211;
      for (int k = 0; k < 5; k++) begin
         exp_idx  = k % 4;
         exp_oh   = 4'b0001 << exp_idx;
         exp_byte = 8'((exp_idx + 1) * 8'h11);
         wait_start(cyc);
         n_tests++;
         if (tx_start !== 1'b1 || grant !== exp_oh || tx_data !== exp_byte) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got start=%b grant=%b data=%h want 1/%b/%h",
                     k, tx_start, grant, tx_data, exp_oh, exp_byte);
         end
         step();
         tx_done = 1'b1;
         step();
         n_tests++;
         if (ack !== exp_oh || err !== 4'b0) begin
            n_fail++;
            $display("FAIL rr_ack%0d: got ack=%b err=%b want %b/0000", k, ack, err, exp_oh);
         end
         tx_done = 1'b0;
      end
      req = '0;
      repeat (3) step();
   endtask

   task automatic test_timeout();
      int cyc;
      int bad;
      apply_reset();
      req      = 4'b0100;
      req_data = 32'h0077_0000;
      wait_start(cyc);
      n_tests++;
      if (tx_start !== 1'b1 || grant !== 4'b0100 || tx_data !== 8'h77) begin
         n_fail++;
         $display("FAIL to_start: got start=%b grant=%b data=%h want 1/0100/77", tx_start, grant, tx_data);
      end
      bad = 0;
      for (int i = 1; i < 16; i++) begin
         step();
         if (err !== 4'b0 || ack !== 4'b0 || tx_start !== 1'b1) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL to_early: got %0d bad cycles want 0", bad);
      end
      step();
      n_tests++;
      if (err !== 4'b0100 || ack !== 4'b0 || tx_start !== 1'b0) begin
         n_fail++;
         $display("FAIL to_err: got err=%b ack=%b start=%b want 0100/0000/0", err, ack, tx_start);
      end
      req = '0;
      step();
      n_tests++;
      if (err !== 4'b0) begin
         n_fail++;
         $display("FAIL to_err_once: got err=%b want 0000", err);
      end
      req      = 4'b1001;
      req_data = 32'hD000_00E0;
      wait_start(cyc);
      n_tests++;
      if (grant !== 4'b1000 || tx_data !== 8'hD0) begin
         n_fail++;
         $display("FAIL to_pointer: got grant=%b data=%h want 1000/d0", grant, tx_data);
      end
      step();
      tx_done = 1'b1;
      step();
      n_tests++;
      if (ack !== 4'b1000) begin
         n_fail++;
         $display("FAIL to_next_ack: got ack=%b want 1000", ack);
      end
      tx_done = 1'b0;
      req     = '0;
      repeat (3) step();
   endtask

   task automatic test_stale_done();
      int cyc;
      int bad;
      apply_reset();
      tx_done = 1'b1;
      step();
      step();
      req      = 4'b0001;
      req_data = 32'h0000_003C;
      wait_start(cyc);
      n_tests++;
      if (tx_start !== 1'b1 || grant !== 4'b0001) begin
         n_fail++;
         $display("FAIL stale_start: got start=%b grant=%b want 1/0001", tx_start, grant);
      end
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (ack !== 4'b0) bad++;
      end
      tx_done = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         if (ack !== 4'b0) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL stale_no_ack: got %0d early ack cycles want 0", bad);
      end
      tx_done = 1'b1;
      step();
      n_tests++;
      if (ack !== 4'b0001) begin
         n_fail++;
         $display("FAIL stale_ack: got ack=%b want 0001", ack);
      end
      tx_done = 1'b0;
      req     = '0;
      repeat (3) step();
   endtask

   // Starts with the pointer at 1, left there by the previous scenario.
   task automatic test_reset_mid();
      int cyc;
      req      = 4'b0011;
      req_data = 32'h0000_2211;
      wait_start(cyc);
      n_tests++;
      if (grant !== 4'b0010) begin
         n_fail++;
         $display("FAIL rmid_setup: got grant=%b want 0010", grant);
      end
      step();
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({ack, err, grant, busy, tx_start, tx_data} !== 22'h0) begin
         n_fail++;
         $display("FAIL rmid_async: got ack=%b err=%b grant=%b busy=%b start=%b data=%h want all 0",
                  ack, err, grant, busy, tx_start, tx_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_start(cyc);
      n_tests++;
      if (tx_start !== 1'b1 || grant !== 4'b0001 || tx_data !== 8'h11) begin
         n_fail++;
         $display("FAIL rmid_restart: got start=%b grant=%b data=%h want 1/0001/11", tx_start, grant, tx_data);
      end
      step();
      tx_done = 1'b1;
      step();
      n_tests++;
      if (ack !== 4'b0001 || err !== 4'b0) begin
         n_fail++;
         $display("FAIL rmid_ack: got ack=%b err=%b want 0001/0000", ack, err);
      end
      tx_done = 1'b0;
      req     = '0;
      step();
      n_tests++;
      if (ack !== 4'b0) begin
         n_fail++;
         $display("FAIL rmid_ack_once: got ack=%b want 0000", ack);
      end
      repeat (2) step();
   endtask

`ifdef UART_LOOPBACK_CHECK_EN
   task automatic test_loopback();
      int cyc;
      apply_reset();
      n_tests++;
      if (err_cnt !== 8'd0 || mismatch !== 1'b0) begin
         n_fail++;
         $display("FAIL lb_reset: got err_cnt=%0d mismatch=%b want 0/0", err_cnt, mismatch);
      end
      rx_data = 8'h00;
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
      step();
      n_tests++;
      if (err_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL lb_idle_ignored: got err_cnt=%0d want 0", err_cnt);
      end
      req      = 4'b0001;
      req_data = 32'h0000_00C3;
      wait_start(cyc);
      rx_data = 8'h00;
      rx_done = 1'b1;
      step();
      n_tests++;
      if (mismatch !== 1'b1 || err_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL lb_mismatch: got mismatch=%b err_cnt=%0d want 1/1", mismatch, err_cnt);
      end
      rx_done = 1'b0;
      step();
      n_tests++;
      if (mismatch !== 1'b0) begin
         n_fail++;
         $display("FAIL lb_pulse: got mismatch=%b want 0", mismatch);
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      req     = '0;
      repeat (3) step();
      req      = 4'b0001;
      req_data = 32'h0000_005A;
      wait_start(cyc);
      rx_data = 8'h5A;
      rx_done = 1'b1;
      step();
      n_tests++;
      if (mismatch !== 1'b0 || err_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL lb_match: got mismatch=%b err_cnt=%0d want 0/1", mismatch, err_cnt);
      end
      rx_done = 1'b0;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      req     = '0;
      repeat (3) step();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_stale_done();
      test_reset_mid();
`ifdef UART_LOOPBACK_CHECK_EN
      test_loopback();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
